// File: rtl/lfsr_solution_source.sv
// Seeded 32-bit Galois LFSR stimulus source for the OneMax solver:
// fills a random initial vector, then streams in-range flip indices.
module lfsr_solution_source #(
  parameter int unsigned N_BITS = 1024,
  parameter logic [31:0] SEED   = 32'h0000_0001,
  localparam int IDX_W          = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [31:0]       seed_in,
  input  logic              start,
  input  logic              stop,
  output logic [N_BITS-1:0] init_solution,
  output logic              init_valid,
  output logic [IDX_W-1:0]  idx,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic              busy
);

  localparam int CHUNKS = (N_BITS + 31) / 32;
  localparam int CNT_W  = $clog2(CHUNKS + 1);

  localparam logic [31:0] POLY = 32'h8020_0003;

  localparam logic [CNT_W-1:0] LAST_CHUNK =
    CNT_W'(CHUNKS - 1);
  localparam logic [IDX_W:0] IDX_LIMIT =
    (IDX_W + 1)'(N_BITS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BITS-1:0] sol_q, sol_d;
  logic              iv_q, iv_d;

  logic st_idle;
  logic st_fill;
  logic st_stream;
  logic in_range;

  function automatic logic [31:0] step(
    input logic [31:0] s
  );
    step = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  assign st_idle   = (state_q == S_IDLE);
  assign st_fill   = (state_q == S_FILL);
  assign st_stream = (state_q == S_STREAM);

  // Unsigned compare one bit wider so N_BITS itself is representable.
  assign in_range =
    ({1'b0, lfsr_q[IDX_W-1:0]} < IDX_LIMIT);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    iv_d    = 1'b0;
    sol_d   = sol_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (seed_load) begin
            lfsr_d = (seed_in == 32'd0) ? SEED : seed_in;
          end
          if (start) begin
            state_d = S_FILL;
            cnt_d   = '0;
          end
        end
        st_fill: begin
          // Bits past N_BITS in the last chunk are simply dropped.
          for (int b = 0; b < int'(N_BITS); b++) begin
            if (cnt_q == CNT_W'(b / 32)) begin
              sol_d[b] = lfsr_q[b % 32];
            end
          end
          lfsr_d = step(lfsr_q);
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CHUNK) begin
            state_d = S_STREAM;
            iv_d    = 1'b1;
          end
        end
        st_stream: begin
          if (!in_range || idx_ready) begin
            lfsr_d = step(lfsr_q);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      sol_q   <= '0;
      iv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      sol_q   <= sol_d;
      iv_q    <= iv_d;
    end
  end

  assign init_solution = sol_q;
  assign init_valid    = iv_q;
  assign idx           = lfsr_q[IDX_W-1:0];
  assign idx_valid     = st_stream && in_range;
  assign busy          = !st_idle;

endmodule

// File: doc/lfsr_solution_source.md
Name: lfsr_solution_source

Overview:
- Synthesizable random-stimulus source that sits directly upstream of the OneMax hill-climbing solver.
- On start, it generates an N_BITS-wide random initial solution.
- It then streams random bit-flip indices in [0, N_BITS-1] over a valid/ready handshake.
- Replaces simulation-only random calls with a seeded 32-bit Galois LFSR, so runs are reproducible and synthesizable.

Parameters:
- N_BITS, 1024, solution vector width; must be ≥ 2.
- SEED, 32'h0000_0001, reset and fallback LFSR state; must be nonzero.
- IDX_W, $clog2(N_BITS), derived localparam: index width.
- CHUNKS, (N_BITS+31)/32, derived localparam: fill cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- seed_load  in  1  load seed_in into LFSR (IDLE only)
- seed_in  in  32  seed value
- start  in  1  begin fill + stream (IDLE only)
- stop  in  1  abort and return to IDLE
- init_solution  out  N_BITS  random initial vector
- init_valid  out  1  one-cycle pulse: init_solution complete
- idx  out  IDX_W  random bit index
- idx_valid  out  1  idx is valid
- idx_ready  in  1  consumer accepts idx
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Registers: state=IDLE, lfsr=SEED, chunk counter=0.
  - Outputs: init_solution=0, init_valid=0, idx_valid=0, busy=0.
  - idx equals lfsr[IDX_W-1:0]; it is don't-care while idx_valid=0.
- LFSR step(s): right-shift Galois, polynomial x^32+x^22+x^2+x+1.
  - next = s[0] ? (s>>1) ^ 32'h8020_0003 : (s>>1).
  - The LFSR advances only where stated below.
- States and transitions: IDLE, FILL, STREAM.
- IDLE:
  - seed_load=1 → lfsr <= (seed_in==0) ? SEED : seed_in. The LFSR never holds 0.
  - start=1 → FILL, counter <= 0.
  - If seed_load and start are both high: seed loads and state → FILL in the same edge.
  - seed_load outside IDLE is ignored.
- FILL (counter k = 0..CHUNKS-1), each edge:
  - init_solution[32k +: 32] <= lfsr. The last chunk is truncated to N_BITS.
  - lfsr <= step(lfsr); counter++.
  - On the edge writing chunk CHUNKS-1: state → STREAM and init_valid <= 1.
  - Latency: start edge to init_valid high = CHUNKS+1 edges.
  - init_valid is high for exactly one cycle, coinciding with the first STREAM cycle.
- STREAM:
  - idx = lfsr[IDX_W-1:0] (combinational from the register).
  - idx_valid = (lfsr[IDX_W-1:0] < N_BITS).
  - idx_valid=0 (rejection) → lfsr <= step(lfsr) every cycle until a candidate is in range.
  - idx_valid=1 && idx_ready=1 → transfer; lfsr <= step(lfsr).
  - idx_valid=1 && idx_ready=0 → lfsr holds; idx stays stable until accepted. idx_valid never drops without a transfer.
  - If N_BITS is a power of two, idx_valid is constant 1 in STREAM.
- Holding of init_solution: held from init_valid until the next start. Contents are trusted only on init_valid.
- stop (priority over all, any state): next edge state → IDLE, idx_valid → 0, no init_valid.
  - A partially filled init_solution is retained but is not valid.
  - lfsr keeps its current value; it is not reseeded.
  - start in FILL/STREAM is ignored. stop && start in IDLE → stays IDLE.
- Reset mid-operation: immediate return to reset values; any pending idx is discarded.
- Widths and arithmetic:
  - Comparison is unsigned, at IDX_W+1 bits.
  - Counter width is $clog2(CHUNKS+1).

Test Plan:
- Reset: assert rst_n=0 mid-clock → init_solution=0, init_valid=0, idx_valid=0, busy=0 immediately, without waiting for a clock edge.
- Fill, N_BITS=64, SEED=1:
  - Stimulus: pulse start.
  - init_valid=1 exactly 3 edges after start, for one cycle.
  - init_solution=64'h80200003_00000001.
  - First idx=2 (lfsr=32'hC030_0002), idx_valid=1.
- Backpressure, N_BITS=64: hold idx_ready=0 for 5 cycles in STREAM → idx constant at 2 and lfsr unchanged. Raise idx_ready → next idx equals the low 6 bits of step(32'hC030_0002)=32'h6018_0001, i.e. 1.
- Rejection, N_BITS=40: stream 10,000 transfers with idx_ready=1 → every accepted idx < 40. Every cycle with an out-of-range candidate shows idx_valid=0. The sequence matches the reference-model LFSR.
- Seed handling:
  - seed_load with seed_in=0 in IDLE → lfsr=SEED.
  - seed_load during STREAM → ignored; the sequence is unchanged.
  - Reseeding 32'hDEAD_BEEF twice gives an identical init_solution each time.
- Stop/abort: assert stop during FILL (CHUNKS=32, N_BITS=1024) at cycle 10 → IDLE next edge, no init_valid, busy=0. A following start fills normally and init_valid occurs after 33 edges.
